// File: rtl/sevenseg_capture.sv
// sevenseg_capture: decodes a scanned, active-low 7-segment bus back into
// per-digit BCD and commits each digit after it reads back stably.
//
// Ports:
//   clk, rst     clock and async active-high reset
//   an           anode strobes, active-low, one-hot-low when a digit is driven
//   seg          segment lines, active-low, bit6=a .. bit0=g
//   digits       committed BCD values, digit i at [4i+3:4i] (4'hF = blank/none)
//   digit_valid  bit i set once digit i has been committed
//   update       one-cycle pulse when a committed value or valid bit changes
//   bad_pattern  one-cycle pulse for an illegal sampled segment pattern
//   bad_index    digit index of the most recent illegal pattern
module sevenseg_capture #(
    parameter  int DIGITS       = 4,
    parameter  int SETTLE       = 3,
    parameter  int STABLE_SCANS = 2,
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIGITS-1:0]   an,
    input  logic [6:0]          seg,
    output logic [4*DIGITS-1:0] digits,
    output logic [DIGITS-1:0]   digit_valid,
    output logic                update,
    output logic                bad_pattern,
    output logic [IW-1:0]       bad_index
);

    localparam int DW = $clog2(SETTLE + 1);
    localparam int CW = $clog2(STABLE_SCANS + 1);
    localparam logic [DW-1:0] SETTLE_V = DW'(SETTLE);
    localparam logic [CW-1:0] STABLE_V = CW'(STABLE_SCANS);

    logic [DIGITS-1:0] an_r;
    logic [6:0]        seg_r;
    logic [DW-1:0]     dwell;
    logic [DW-1:0]     dwell_nxt;
    logic              one_hot;
    logic              take;
    logic [IW-1:0]     idx;
    logic [3:0]        dec_val;
    logic              dec_legal;

    // Captured sample, applied to the stability tracker one cycle later.
    logic              s_fire;
    logic              s_legal;
    logic [IW-1:0]     s_idx;
    logic [3:0]        s_val;

    logic [3:0]        cand [DIGITS];
    logic [CW-1:0]     cnt  [DIGITS];
    logic [3:0]        dig  [DIGITS];

    logic [3:0]        cur_cand;
    logic [CW-1:0]     cur_cnt;
    logic [CW-1:0]     new_cnt;
    logic              commit;

    assign one_hot = $onehot(~an_r);

    // The counter restarts on the edge that loads a new strobe value, so it
    // counts how long the current an_r has been held.
    always_comb begin
        dwell_nxt = '0;
        if (an == an_r && one_hot) begin
            if (dwell == SETTLE_V)
                dwell_nxt = dwell;
            else
                dwell_nxt = dwell + DW'(1);
        end
    end

    // Exactly one sample per dwell: the cycle the counter reaches SETTLE.
    assign take = (dwell_nxt == SETTLE_V) && (dwell != SETTLE_V);

    always_comb begin
        idx = '0;
        for (int i = 0; i < DIGITS; i++)
            if (!an_r[i])
                idx = IW'(i);
    end

    always_comb begin
        dec_legal = 1'b1;
        dec_val   = 4'hF;
        case (seg_r)
            7'b0000001: dec_val = 4'd0;
            7'b1001111: dec_val = 4'd1;
            7'b0010010: dec_val = 4'd2;
            7'b0000110: dec_val = 4'd3;
            7'b1001100: dec_val = 4'd4;
            7'b0100100: dec_val = 4'd5;
            7'b0100000: dec_val = 4'd6;
            7'b0001111: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0000100: dec_val = 4'd9;
            7'b1111111: dec_val = 4'hF;
            default:    dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_r    <= '1;
            seg_r   <= '1;
            dwell   <= '0;
            s_fire  <= 1'b0;
            s_legal <= 1'b0;
            s_idx   <= '0;
            s_val   <= 4'hF;
        end else begin
            an_r    <= an;
            seg_r   <= seg;
            dwell   <= dwell_nxt;
            s_fire  <= take;
            s_legal <= dec_legal;
            s_idx   <= idx;
            s_val   <= dec_val;
        end
    end

    always_comb begin
        cur_cand = cand[s_idx];
        cur_cnt  = cnt[s_idx];
        if (s_val == cur_cand) begin
            if (cur_cnt == STABLE_V)
                new_cnt = cur_cnt;
            else
                new_cnt = cur_cnt + CW'(1);
        end else begin
            new_cnt = CW'(1);
        end
    end

    // Commit only on the sample that brings the count to STABLE_SCANS and
    // only when it changes what the outside world sees.
    assign commit = s_fire && s_legal && (new_cnt == STABLE_V)
                    && ((s_val != dig[s_idx]) || !digit_valid[s_idx]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                cand[i] <= '0;
                cnt[i]  <= '0;
                dig[i]  <= 4'hF;
            end
            digit_valid <= '0;
            update      <= 1'b0;
            bad_pattern <= 1'b0;
            bad_index   <= '0;
        end else begin
            update      <= 1'b0;
            bad_pattern <= 1'b0;
            if (s_fire) begin
                if (!s_legal) begin
                    cnt[s_idx]  <= '0;
                    bad_pattern <= 1'b1;
                    bad_index   <= s_idx;
                end else begin
                    cand[s_idx] <= s_val;
                    cnt[s_idx]  <= new_cnt;
                end
            end
            if (commit) begin
                dig[s_idx]         <= s_val;
                digit_valid[s_idx] <= 1'b1;
                update             <= 1'b1;
            end
        end
    end

    always_comb begin
        digits = '0;
        for (int i = 0; i < DIGITS; i++)
            digits[4*i +: 4] = dig[i];
    end

endmodule
